// File: rtl/coeff_bank_loader_pkg.sv
// Shared types and constants for the double-buffered coefficient loader.
package coeff_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

  localparam int unsigned DefCoeffW   = 16;
  localparam int unsigned DefNumTaps  = 4;
  localparam int unsigned DefNumBanks = 2;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coeff_bank_loader_if.sv
// Host-side bus of the coefficient loader: load control, word stream, swap and status.
interface coeff_bank_loader_if
  import coeff_loader_pkg::*;
#(
  parameter int unsigned COEFF_W   = DefCoeffW,
  parameter int unsigned NUM_TAPS  = DefNumTaps,
  parameter int unsigned NUM_BANKS = DefNumBanks
);

  localparam int unsigned BANK_W = idx_w(NUM_BANKS);

  logic                                  load_start;
  logic [BANK_W-1:0]                     load_bank;
  logic                                  in_valid;
  logic [COEFF_W-1:0]                    in_data;
  logic                                  in_ready;
  logic                                  swap_req;
  logic                                  busy;
  logic                                  load_done;
  logic                                  err;
  logic [NUM_BANKS-1:0]                  pending;
  logic [NUM_BANKS*NUM_TAPS*COEFF_W-1:0] coeff_out;

  modport master (
    output load_start, load_bank, in_valid, in_data, swap_req,
    input  in_ready, busy, load_done, err, pending, coeff_out
  );

  modport slave (
    input  load_start, load_bank, in_valid, in_data, swap_req,
    output in_ready, busy, load_done, err, pending, coeff_out
  );

endinterface

// File: rtl/coeff_bank_loader_bank.sv
// One coefficient bank: shadow registers written tap by tap, active registers
// updated from the whole shadow set in a single commit.
module coeff_bank #(
  parameter int unsigned COEFF_W  = 16,
  parameter int unsigned NUM_TAPS = 4,
  parameter int unsigned TAP_W    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [TAP_W-1:0]             wr_tap,
  input  logic [COEFF_W-1:0]           wr_data,
  input  logic                         commit,
  output logic [NUM_TAPS*COEFF_W-1:0]  active_out
);

  logic [NUM_TAPS-1:0][COEFF_W-1:0] shadow_q;
  logic [NUM_TAPS-1:0][COEFF_W-1:0] active_q;

  // Shadow takes streamed words; active copies the shadow only on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en) begin
        shadow_q[wr_tap] <= wr_data;
      end
      if (commit) begin
        active_q <= shadow_q;
      end
    end
  end

  assign active_out = active_q;

endmodule

// File: rtl/coeff_bank_loader.sv
// Double-buffered coefficient loader: streams words into one bank's shadow,
// marks it pending when complete, and commits all pending banks on swap_req.
module coeff_bank_loader
  import coeff_loader_pkg::*;
#(
  parameter int unsigned COEFF_W   = DefCoeffW,
  parameter int unsigned NUM_TAPS  = DefNumTaps,
  parameter int unsigned NUM_BANKS = DefNumBanks
) (
  input logic                clk,
  input logic                rst,
  coeff_bank_loader_if.slave bus
);

  localparam int unsigned BANK_W = idx_w(NUM_BANKS);
  localparam int unsigned TAP_W  = idx_w(NUM_TAPS);
  localparam int unsigned BANK_BITS = NUM_TAPS * COEFF_W;

  state_e               state_q, state_d;
  logic [TAP_W-1:0]     cnt_q, cnt_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [NUM_BANKS-1:0] pending_q, pending_d;
  logic                 err_q, err_d;
  logic                 wr_en;
  logic                 bank_ok;
  logic                 last_tap;
  logic [NUM_BANKS*BANK_BITS-1:0] coeff_flat;

  assign bank_ok  = 32'(bus.load_bank) < NUM_BANKS;
  assign last_tap = cnt_q == TAP_W'(NUM_TAPS - 1);

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bank_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Next-state, pending bookkeeping and write strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    pending_d = pending_q;
    err_d     = 1'b0;
    wr_en     = 1'b0;

    // A swap commits every registered pending bank, so all bits drop; a bank
    // finishing on the same edge is re-set below and waits for the next swap.
    if (bus.swap_req) begin
      pending_d = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.load_start) begin
          if (bank_ok) begin
            bank_d                   = bus.load_bank;
            cnt_d                    = '0;
            pending_d[bus.load_bank] = 1'b0;
            state_d                  = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        err_d = bus.load_start;
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (last_tap) begin
            pending_d[bank_q] = 1'b1;
            cnt_d             = '0;
            state_d           = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        err_d   = bus.load_start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    coeff_bank #(
      .COEFF_W  (COEFF_W),
      .NUM_TAPS (NUM_TAPS),
      .TAP_W    (TAP_W)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en && (bank_q == BANK_W'(b))),
      .wr_tap     (cnt_q),
      .wr_data    (bus.in_data),
      .commit     (bus.swap_req && pending_q[b]),
      .active_out (coeff_flat[b*BANK_BITS +: BANK_BITS])
    );
  end

  assign bus.in_ready  = state_q == StLoad;
  assign bus.busy      = state_q != StIdle;
  assign bus.load_done = state_q == StDone;
  assign bus.err       = err_q;
  assign bus.pending   = pending_q;
  assign bus.coeff_out = coeff_flat;

endmodule
